// File: rtl/seq_shift_add_mult.sv
// Unsigned WIDTH x WIDTH -> 2*WIDTH sequential shift-add multiplier with valid/ready handshakes.
// The partial-product accumulation uses a 4-bit-block carry-select adder (carry_select).

module carry_select #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int BLOCKS = WIDTH / 4;

  logic [BLOCKS:0] carry;

  assign carry[0] = cin;

  // Each block precomputes both carry-in outcomes; the incoming carry only drives a mux.
  for (genvar g = 0; g < BLOCKS; g++) begin : g_blk
    logic [4:0] sum0;
    logic [4:0] sum1;

    assign sum0 = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]};
    assign sum1 = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]} + 5'd1;

    assign sum[4*g +: 4] = carry[g] ? sum1[3:0] : sum0[3:0];
    assign carry[g+1]    = carry[g] ? sum1[4]   : sum0[4];
  end

  assign cout = carry[BLOCKS];
endmodule

module seq_shift_add_mult #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] p;
  logic [2*WIDTH-1:0] p_next;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic               accept;
  logic               last;

  // in_ready is a register that is only set in IDLE, so accept implies IDLE.
  assign accept = in_valid && in_ready;
  assign last   = (count == CW'(WIDTH - 1));
  assign add_b  = p[0] ? mcand : '0;

  carry_select #(.WIDTH(WIDTH)) u_adder (
    .a    (p[2*WIDTH-1:WIDTH]),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // The adder carry becomes the new MSB, so no result bit is lost.
  assign p_next = {cout, sum, p[WIDTH-1:1]};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: defaults first in always_comb so no path leaves an output unassigned (no latch).
  always_comb begin
    state_next = state;
    out_valid  = 1'b0;
    case (state)
      IDLE: if (accept) state_next = BUSY;
      BUSY: if (last)   state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready <= 1'b0;
      mcand    <= '0;
      p        <= '0;
      count    <= '0;
      product  <= '0;
    end else begin
      // Registered ready keeps in_valid off any combinational path to in_ready.
      in_ready <= (state_next == IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            mcand <= a;
            p     <= {{WIDTH{1'b0}}, b};
            count <= '0;
          end
        end
        BUSY: begin
          p     <= p_next;
          count <= count + CW'(1);
          if (last) product <= p_next;
        end
        default: ;
      endcase
    end
  end
endmodule
